// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the variable-latency data-memory
// responder.
//   state_e : responder FSM states
//   op_e    : latched access kind (OP_NONE marks a read+write conflict)
//   lat_w() : width of the latency down-counter for a given LATENCY
package dmem_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} op_e;

  // The counter holds values LATENCY-1 down to 0. It needs at least one bit.
  function automatic int lat_w(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array: DEPTH x 32-bit word storage.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset; clears every word to 0
//   we_i    : write enable
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : read word index (asynchronous read)
//   rdata_o : read data
module dmem_word_array #(
  parameter int DEPTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder that stalls the CPU MEM stage for
// LATENCY+1 cycles per access, then completes it in a one-cycle DONE state.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   MemRead_i  : read request (held while stall_o=1)
//   MemWrite_i : write request (held while stall_o=1)
//   addr_i     : byte address
//   data_i     : write data
//   stall_o    : pipeline freeze, combinational
//   data_o     : read data, valid in DONE and held until the next completion
//   done_o     : one-cycle completion pulse
//   err_o      : one-cycle illegal-access pulse, coincident with done_o
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        stall_o,
  output logic [31:0] data_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = lat_w(LATENCY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      data_q;
  logic             err_q;

  logic             req;
  logic             finish;
  logic             illegal;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  assign req    = MemRead_i | MemWrite_i;
  assign finish = (state_q == S_BUSY) && (cnt_q == '0);

  // Legality is judged on the latched request. A simultaneous read and
  // write is latched as OP_NONE, so it lands here as well.
  assign illegal = (op_q == OP_NONE) ||
                   (addr_q[1:0] != 2'b00) ||
                   ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

  assign mem_we = finish && !illegal && (op_q == OP_WR);

  dmem_word_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .waddr_i (addr_q[IDX_W+1:2]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[IDX_W+1:2]),
    .rdata_o (mem_rdata)
  );

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. DONE never looks at req; the pipeline advances on that edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. Stall is forced low during reset so the pipe is not frozen.
  always_comb begin
    stall_o = 1'b0;
    done_o  = 1'b0;
    if (!rst_i) begin
      stall_o = ((state_q == S_IDLE) && req) || (state_q == S_BUSY);
    end
    if (state_q == S_DONE) begin
      done_o = 1'b1;
    end
  end

  // Request latch, latency counter and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if ((state_q == S_IDLE) && req) begin
        cnt_q   <= CNT_W'(LATENCY - 1);
        addr_q  <= addr_i;
        wdata_q <= data_i;
        if (MemRead_i && MemWrite_i) begin
          op_q <= OP_NONE;
        end else if (MemWrite_i) begin
          op_q <= OP_WR;
        end else begin
          op_q <= OP_RD;
        end
      end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (finish) begin
        if (illegal) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end else if (op_q == OP_RD) begin
          data_q <= mem_rdata;
        end
      end
    end
  end

  assign data_o = data_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. Instance a uses
// LATENCY=2 and instance b uses LATENCY=1. Both use DEPTH=128.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_rd, a_wr, a_stall, a_done, a_err;
  logic [31:0] a_addr, a_wdata, a_data;
  logic        b_rd, b_wr, b_stall, b_done, b_err;
  logic [31:0] b_addr, b_wdata, b_data;

  dmem_responder #(.DEPTH(128), .LATENCY(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .MemRead_i(a_rd), .MemWrite_i(a_wr),
    .addr_i(a_addr), .data_i(a_wdata), .stall_o(a_stall), .data_o(a_data),
    .done_o(a_done), .err_o(a_err)
  );

  dmem_responder #(.DEPTH(128), .LATENCY(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .MemRead_i(b_rd), .MemWrite_i(b_wr),
    .addr_i(b_addr), .data_i(b_wdata), .stall_o(b_stall), .data_o(b_data),
    .done_o(b_done), .err_o(b_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cyc [2];
  logic [31:0] mdl_mem [2][128];
  logic [31:0] mdl_out [2];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mdl_out[s] = '0;
      for (int w = 0; w < 128; w++) mdl_mem[s][w] = '0;
    end
  endtask

  function automatic logic get_stall(input int sel);
    return (sel != 0) ? b_stall : a_stall;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel != 0) ? b_done : a_done;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel != 0) ? b_err : a_err;
  endfunction
  function automatic logic [31:0] get_data(input int sel);
    return (sel != 0) ? b_data : a_data;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel != 0) begin
      b_rd = rd; b_wr = wr; b_addr = a; b_wdata = d;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = a; a_wdata = d;
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 with the request removed.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    exp_t e;
    logic ill;
    int   idx;
    int   stalls;
    bit   seen;

    ill = (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'd128) || (rd && wr);
    idx = int'(a[8:2]);
    if (ill) begin
      mdl_out[sel] = '0;
    end else if (rd) begin
      mdl_out[sel] = mdl_mem[sel][idx];
    end else begin
      mdl_mem[sel][idx] = d;
    end
    e.data   = mdl_out[sel];
    e.err    = ill;
    e.stalls = (sel != 0) ? 2 : 3;
    sb.push_back(e);

    drive(sel, rd, wr, a, d);
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (get_done(sel)) begin
        seen = 1'b1;
        break;
      end
      if (get_stall(sel)) stalls++;
    end

    e = sb.pop_front();
    chk({tag, ":done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      done_cyc[sel] = cyc;
      chk({tag, ":stall_in_done"}, 32'(get_stall(sel)), 32'd0);
      chk({tag, ":stall_cycles"}, 32'(stalls), 32'(e.stalls));
      chk({tag, ":data_o"}, get_data(sel), e.data);
      chk({tag, ":err_o"}, 32'(get_err(sel)), 32'(e.err));
    end
    $display("txn %s dut=%0d rd=%b wr=%b addr=%h wdata=%h data_o=%h err_o=%b stalls=%0d",
             tag, sel, rd, wr, a, d, get_data(sel), get_err(sel), stalls);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int d0;
    model_reset();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    // Reset with requests present: stall must stay low, outputs at zero.
    rst = 1'b1;
    a_rd = 1'b1;
    b_rd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:a_stall", 32'(a_stall), 32'd0);
    chk("rst:b_stall", 32'(b_stall), 32'd0);
    chk("rst:a_done", 32'(a_done), 32'd0);
    chk("rst:a_err", 32'(a_err), 32'd0);
    chk("rst:a_data", a_data, 32'd0);
    chk("rst:b_data", b_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    // LATENCY=2: write/read, write leaves data_o alone, read-after-write.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd_10");
    access(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, "wr_20_keeps_data");
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, "rd_misaligned");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd_10_unchanged");
    access(0, 1'b0, 1'b1, 32'h200, 32'h12345678, "wr_out_of_range");
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, "rd_word0");
    access(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, "rd_wr_both");
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, "rd_8_no_write");
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, "rd_20");

    // Reset in the first BUSY cycle of a write of 0x5 to 0x4.
    drive(0, 1'b0, 1'b1, 32'h4, 32'h5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst:stall", 32'(a_stall), 32'd0);
    chk("midrst:done", 32'(a_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(negedge clk);
    chk("after_rst:stall", 32'(a_stall), 32'd0);
    chk("after_rst:done", 32'(a_done), 32'd0);
    @(posedge clk);
    #1;
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, "rd_4_after_rst");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd_10_after_rst");

    // LATENCY=1: back-to-back reads complete exactly 3 cycles apart.
    access(1, 1'b0, 1'b1, 32'h0, 32'h11111111, "b_wr_0");
    access(1, 1'b0, 1'b1, 32'h4, 32'h22222222, "b_wr_4");
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, "b_rd_0");
    d0 = done_cyc[1];
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, "b_rd_4");
    chk("b2b_spacing", 32'(done_cyc[1] - d0), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
